// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execute unit.
// Multiply uses a 32-step shift-add over a 64-bit accumulator. Divide uses a
// 32-step restoring divider. Magnitudes are iterated and the sign is applied
// on the final step.
// Optional feature macro: MULDIV_DIV_EN. When it is defined, the divider is
// built and DIV/DIVU/REM/REMU are implemented. When it is undefined, requests
// with funct3[2]=1 complete in one cycle with result 0.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [4:0]      LAST_ITER = 5'd31;
  localparam logic [XLEN-1:0] ZERO      = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES      = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  // Two's-complement negation of one word.
  function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] v);
    f_neg = ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  // Two's-complement negation of a double-width product.
  function automatic logic [2*XLEN-1:0] f_neg2x(input logic [2*XLEN-1:0] v);
    f_neg2x = ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
  endfunction

  // Control and output registers.
  state_t          r_state;
  logic [4:0]      r_count;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_rd_out;

  // Operation context captured on accept.
  logic [2:0]      r_funct3;
  logic [4:0]      r_rd;
  logic            r_neg;

  // Shared iteration datapath.
  // Multiply: r_hi is the upper accumulator, r_lo holds the shifting
  //   multiplier, and r_opnd is the multiplicand.
  // Divide: r_hi is the partial remainder, r_lo holds the shifting dividend and
  //   the quotient, and r_opnd is the divisor.
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_opnd;

  // Accept-time decode.
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic            w_res_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;

  // One iteration step and the final result.
  logic [XLEN:0]     w_sum;
  logic [XLEN-1:0]   w_hi_next;
  logic [XLEN-1:0]   w_lo_next;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_adj;
  logic [XLEN-1:0]   w_final;

`ifdef MULDIV_DIV_EN
  logic [XLEN:0]   w_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_diff;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign result    = r_result;
  assign rd_out    = r_rd_out;

  // Decode operand signedness, magnitudes and the sign of the final result.
  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (funct3)
      3'b001: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
      3'b010: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b0;
      end
      3'b100, 3'b110: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
      default: begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
      end
    endcase
    w_a_neg = w_a_signed & op_a[XLEN-1];
    w_b_neg = w_b_signed & op_b[XLEN-1];
    w_a_mag = w_a_neg ? f_neg(op_a) : op_a;
    w_b_mag = w_b_neg ? f_neg(op_b) : op_b;
    // A remainder follows the sign of the dividend.
    // Products and quotients are negative when the operand signs differ.
    if (funct3 == 3'b110) begin
      w_res_neg = w_a_neg;
    end else begin
      w_res_neg = w_a_neg ^ w_b_neg;
    end
  end

  // Detect requests that finish without iterating, and their fixed result.
  always_comb begin
    w_special     = 1'b0;
    w_special_res = ZERO;
`ifdef MULDIV_DIV_EN
    if (funct3[2]) begin
      if (op_b == ZERO) begin
        // Divide by zero: the quotient is all ones and the remainder is the dividend.
        w_special     = 1'b1;
        w_special_res = funct3[1] ? op_a : ONES;
      end else if (w_b_signed && (op_a == MIN_NEG) && (op_b == ONES)) begin
        // Signed overflow: the quotient is the most negative value and the remainder is zero.
        w_special     = 1'b1;
        w_special_res = funct3[1] ? ZERO : MIN_NEG;
      end else begin
        w_special     = 1'b0;
        w_special_res = ZERO;
      end
    end else begin
      w_special     = 1'b0;
      w_special_res = ZERO;
    end
`else
    // Without a divider, every divide-class request returns zero immediately.
    if (funct3[2]) begin
      w_special     = 1'b1;
      w_special_res = ZERO;
    end else begin
      w_special     = 1'b0;
      w_special_res = ZERO;
    end
`endif
  end

  // One shift-add (multiply) or restoring-subtract (divide) step.
  always_comb begin
    w_sum     = {(XLEN+1){1'b0}};
    w_hi_next = r_hi;
    w_lo_next = r_lo;
`ifdef MULDIV_DIV_EN
    w_shift   = {(XLEN+1){1'b0}};
    w_ge      = 1'b0;
    w_diff    = ZERO;
`endif
    if (!r_funct3[2]) begin
      // Add the multiplicand when the multiplier LSB is set, then shift the
      // 65-bit {carry, hi, lo} right by one.
      w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
      w_hi_next = w_sum[XLEN:1];
      w_lo_next = {w_sum[0], r_lo[XLEN-1:1]};
    end else begin
`ifdef MULDIV_DIV_EN
      // Bring the next dividend bit into the remainder and try the subtraction.
      // When w_ge is set, the true difference is smaller than the divisor, so
      // a word-wide subtraction is exact.
      w_shift   = {r_hi, r_lo[XLEN-1]};
      w_ge      = (w_shift >= {1'b0, r_opnd});
      w_diff    = w_shift[XLEN-1:0] - r_opnd;
      w_hi_next = w_ge ? w_diff : w_shift[XLEN-1:0];
      w_lo_next = {r_lo[XLEN-2:0], w_ge};
`else
      w_hi_next = r_hi;
      w_lo_next = r_lo;
`endif
    end
  end

  // Select the requested half or word from the last step and apply the sign.
  always_comb begin
    w_prod     = {w_hi_next, w_lo_next};
    w_prod_adj = r_neg ? f_neg2x(w_prod) : w_prod;
    w_final    = ZERO;
    case (r_funct3)
      3'b000:                 w_final = w_prod_adj[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod_adj[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
      3'b100, 3'b101:         w_final = r_neg ? f_neg(w_lo_next) : w_lo_next;
      3'b110, 3'b111:         w_final = r_neg ? f_neg(w_hi_next) : w_hi_next;
`endif
      default:                w_final = ZERO;
    endcase
  end

  // Control FSM with its datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= 5'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= ZERO;
      r_rd_out    <= 5'd0;
      r_funct3    <= 3'd0;
      r_rd        <= 5'd0;
      r_neg       <= 1'b0;
      r_hi        <= ZERO;
      r_lo        <= ZERO;
      r_opnd      <= ZERO;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_funct3   <= funct3;
            r_rd       <= rd_in;
            r_neg      <= w_res_neg;
            r_count    <= 5'd0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            // Multiplication is commutative, so both operation classes load
            // A into the shifting register and B into the fixed operand.
            r_hi       <= ZERO;
            r_lo       <= w_a_mag;
            r_opnd     <= w_b_mag;
            if (w_special) begin
              // out_valid is raised one edge later, in DONE.
              r_state  <= S_DONE;
              r_result <= w_special_res;
              r_rd_out <= rd_in;
            end else begin
              r_state  <= S_CALC;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_hi <= w_hi_next;
          r_lo <= w_lo_next;
          if (r_count == LAST_ITER) begin
            r_state     <= S_DONE;
            r_count     <= 5'd0;
            r_out_valid <= 1'b1;
            r_result    <= w_final;
            r_rd_out    <= r_rd;
          end else begin
            r_count <= r_count + 5'd1;
          end
        end
        S_DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_count     <= 5'd0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit.
// A transaction-level model predicts handshake timing and results.
// Hand-computed literals pin each result and latency.
module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .rd_in     (rd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .rd_out    (rd_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural result of an RV32M operation.
  function automatic logic [31:0] model_res(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    int sa;
    int sb;
    sa = a;
    sb = b;
    p = 64'd0;
    model_res = 32'd0;
    case (f)
      3'b000: begin p = {32'd0, a} * {32'd0, b}; model_res = p[31:0]; end
      3'b001: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; model_res = p[63:32]; end
      3'b010: begin p = {{32{a[31]}}, a} * {32'd0, b}; model_res = p[63:32]; end
      3'b011: begin p = {32'd0, a} * {32'd0, b}; model_res = p[63:32]; end
      3'b100: begin
        if (!DIV_EN) model_res = 32'd0;
        else if (b == 32'd0) model_res = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model_res = 32'h8000_0000;
        else model_res = sa / sb;
      end
      3'b101: begin
        if (!DIV_EN) model_res = 32'd0;
        else if (b == 32'd0) model_res = 32'hFFFF_FFFF;
        else model_res = a / b;
      end
      3'b110: begin
        if (!DIV_EN) model_res = 32'd0;
        else if (b == 32'd0) model_res = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model_res = 32'd0;
        else model_res = sa % sb;
      end
      default: begin
        if (!DIV_EN) model_res = 32'd0;
        else if (b == 32'd0) model_res = a;
        else model_res = a % b;
      end
    endcase
  endfunction

  // Edges from accept until out_valid is shown.
  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    model_lat = 32;
    if (f[2]) begin
      if (!DIV_EN) model_lat = 1;
      else if (b == 32'd0) model_lat = 1;
      else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model_lat = 1;
      else model_lat = 32;
    end
  endfunction

  // Transaction model: 0 = idle, 1 = computing, 2 = result offered.
  int          m_phase = 0;
  int          m_wait  = 0;
  logic [31:0] m_res   = 32'd0;
  logic [4:0]  m_rd    = 5'd0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= 0;
      m_wait  <= 0;
      m_res   <= 32'd0;
      m_rd    <= 5'd0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
             m_phase <= 1;
             m_wait  <= model_lat(funct3, op_a, op_b);
             m_res   <= model_res(funct3, op_a, op_b);
             m_rd    <= rd_in;
           end
        1: begin
             if (m_wait <= 1) m_phase <= 2;
             m_wait <= m_wait - 1;
           end
        2: if (out_ready) m_phase <= 0;
        default: m_phase <= 0;
      endcase
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_rd_out", {27'd0, rd_out}, 32'd0);
    end else begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (m_phase == 0)});
      chk("busy", {31'd0, busy}, {31'd0, (m_phase != 0)});
      chk("out_valid", {31'd0, out_valid}, {31'd0, (m_phase == 2)});
      if (m_phase == 2) begin
        chk("result", result, m_res);
        chk("rd_out", {27'd0, rd_out}, {27'd0, m_rd});
      end
    end
  end

  // Issue one request.
  // Scramble the inputs after accept, check latency and result against
  // literals, and optionally stall the output for 'hold' cycles.
  task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd, input logic [31:0] lit,
                     input int lit_lat, input int hold);
    int n;
    logic [31:0] e_res;
    int e_lat;
    e_res = lit;
    e_lat = lit_lat;
    if (f[2] && !DIV_EN) begin
      e_res = 32'd0;
      e_lat = 1;
    end
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; rd_in = rd; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0; funct3 = ~f; op_a = ~a; op_b = b + 32'd1; rd_in = ~rd;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "/latency"}, n, e_lat);
    chk({tag, "/result"}, result, e_res);
    chk({tag, "/rd_out"}, {27'd0, rd_out}, {27'd0, rd});
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (i == 3) begin
          in_valid = 1'b1; funct3 = 3'b000; op_a = 32'd2; op_b = 32'd2; rd_in = 5'd17;
        end else begin
          in_valid = 1'b0;
        end
      end
      chk({tag, "/held_result"}, result, e_res);
      chk({tag, "/held_in_ready"}, {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
    end
    @(posedge clk);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0; rd_in = 5'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    run("mul_7x6",      3'b000, 32'd7,          32'd6,          5'd5,  32'd42,         32, 0);
    run("mulh_m1",      3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'h0000_0000,  32, 0);
    run("mulhu_m1",     3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFE,  32, 0);
    run("mulhsu_m1",    3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd3,  32'hFFFF_FFFF,  32, 0);
    run("mul_min_m1",   3'b000, 32'h8000_0000,  32'hFFFF_FFFF,  5'd4,  32'h8000_0000,  32, 0);
    run("mulh_min_min", 3'b001, 32'h8000_0000,  32'h8000_0000,  5'd6,  32'h4000_0000,  32, 0);
    run("div_m7_2",     3'b100, 32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFD,  32, 0);
    run("rem_m7_2",     3'b110, 32'hFFFF_FFF9,  32'd2,          5'd8,  32'hFFFF_FFFF,  32, 0);
    run("divu_100_7",   3'b101, 32'd100,        32'd7,          5'd9,  32'd14,         32, 0);
    run("remu_100_7",   3'b111, 32'd100,        32'd7,          5'd10, 32'd2,          32, 0);
    run("div_5_0",      3'b100, 32'd5,          32'd0,          5'd11, 32'hFFFF_FFFF,  1,  0);
    run("rem_5_0",      3'b110, 32'd5,          32'd0,          5'd12, 32'd5,          1,  0);
    run("divu_5_0",     3'b101, 32'd5,          32'd0,          5'd13, 32'hFFFF_FFFF,  1,  0);
    run("remu_5_0",     3'b111, 32'd5,          32'd0,          5'd14, 32'd5,          1,  0);
    run("div_ovf",      3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd15, 32'h8000_0000,  1,  0);
    run("rem_ovf",      3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd16, 32'd0,          1,  0);
    run("mul_hold",     3'b000, 32'h1234_5678,  32'h0000_0010,  5'd18, 32'h2345_6780,  32, 10);
    run("div_hold",     3'b100, 32'd5,          32'd0,          5'd19, 32'hFFFF_FFFF,  1,  10);

    // Abort a divide mid-flight with an asynchronous reset.
    @(negedge clk);
    funct3 = 3'b100; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd20; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort/out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort/in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort/busy", {31'd0, busy}, 32'd0);
    chk("abort/result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run("mul_after_abort", 3'b000, 32'd3, 32'd3, 5'd21, 32'd9, 32, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
